dot_acc_engine: RTL and testbench

Streaming signed/unsigned dot-product accumulator that generalises the fixed 8-lane, 2-output multiply-sum datapath. It takes LANES operand pairs per beat over a valid/ready handshake and reduces them through a registered multiplier stage and a registered adder tree. It accumulates across a packet of beats terminated by `last_i` and emits one fully resolved sum per packet on an output valid/ready port. It sits between the operand fetch logic and the result writeback in the AI core datapath.

---
 rtl/dot_acc_pkg.sv | 27 ++
 rtl/dot_acc_tree.sv | 28 ++
 rtl/dot_acc_engine.sv | 208 ++++++++++++++++++++
 tb/tb_dot_acc_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// Width helpers and saturation bounds shared by the dot_acc_engine datapath.
package dot_acc_pkg;

    localparam int MAX_ACC_W = 64;

    function automatic int prod_width(input int in_size_0, input int in_size_1);
        return in_size_0 + in_size_1 + 1;
    endfunction

    function automatic int tree_width(input int prod_w, input int lanes);
        return prod_w + $clog2(lanes);
    endfunction

    function automatic int acc_width(input int tree_w, input int guard);
        return tree_w + guard;
    endfunction

    // Bounds are returned sign-extended to MAX_ACC_W; callers truncate to their width.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_min(input int acc_w);
        return ~sat_max(acc_w);
    endfunction

endpackage

// File: rtl/dot_acc_tree.sv
// Combinational LANES-to-1 signed adder tree; products of width P_W reduce to T_W.
module dot_acc_tree
    import dot_acc_pkg::*;
#(
    parameter int LANES = 8,
    parameter int P_W   = 13,
    parameter int T_W   = tree_width(P_W, LANES)
) (
    input  logic [LANES*P_W-1:0] prod_i,
    output logic [T_W-1:0]       sum_o
);

    localparam int NODES = 2 * LANES - 1;

    // Heap layout: node k sums children 2k+1 and 2k+2, leaves occupy the tail.
    logic [T_W-1:0] node_s [NODES];

    for (genvar l = 0; l < LANES; l++) begin : g_leaf
        assign node_s[LANES-1+l] = {{(T_W-P_W){prod_i[l*P_W+P_W-1]}}, prod_i[l*P_W +: P_W]};
    end

    for (genvar k = 0; k < LANES - 1; k++) begin : g_add
        assign node_s[k] = node_s[2*k+1] + node_s[2*k+2];
    end

    assign sum_o = node_s[0];

endmodule

// File: rtl/dot_acc_engine.sv
// Streaming dot-product accumulator: multiply stage, adder-tree stage, packet accumulator.
// Optional saturation with overflow flag when DOT_ACC_SATURATE_EN is defined.
module dot_acc_engine
    import dot_acc_pkg::*;
#(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int LANES     = 8,
    parameter int ACC_GUARD = 8,
    localparam int P_W      = prod_width(IN_SIZE_0, IN_SIZE_1),
    localparam int T_W      = tree_width(P_W, LANES),
    localparam int ACC_SIZE = acc_width(T_W, ACC_GUARD)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic                       last_i,
    input  logic                       sign_0_i,
    input  logic                       sign_1_i,
    input  logic [LANES*IN_SIZE_0-1:0] in_0_i,
    input  logic [LANES*IN_SIZE_1-1:0] in_1_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ACC_SIZE-1:0]        out_o,
    output logic                       overflow_o
);

    function automatic logic [P_W-1:0] ext_op0(input logic [IN_SIZE_0-1:0] v, input logic s);
        return {{(P_W-IN_SIZE_0){s & v[IN_SIZE_0-1]}}, v};
    endfunction

    function automatic logic [P_W-1:0] ext_op1(input logic [IN_SIZE_1-1:0] v, input logic s);
        return {{(P_W-IN_SIZE_1){s & v[IN_SIZE_1-1]}}, v};
    endfunction

    logic                 en_s;
    logic [LANES*P_W-1:0] prod_s;
    logic [T_W-1:0]       tree_sum_s;
    logic                 acc_step_s;
    logic [ACC_SIZE-1:0]  base_s;
    logic [ACC_SIZE-1:0]  add_s;
    logic [ACC_SIZE-1:0]  raw_s;
    logic [ACC_SIZE-1:0]  acc_next_s;

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q,  s1_last_d;
    logic [LANES*P_W-1:0] s1_prod_q,  s1_prod_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_last_q,  s2_last_d;
    logic [T_W-1:0]       s2_sum_q,   s2_sum_d;
    logic [ACC_SIZE-1:0]  acc_q,      acc_d;
    logic                 first_q,    first_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_SIZE-1:0]  out_q,      out_d;

    // Whole pipeline freezes only while a finished result waits for the consumer.
    assign en_s        = !(out_valid_q && !out_ready_i);
    assign ready_o     = en_s && !rst_i;
    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;

    // Extend each operand by its sign mode; P_W-bit products are exact for every mode mix.
    always_comb begin
        prod_s = '0;
        for (int l = 0; l < LANES; l++) begin
            prod_s[l*P_W +: P_W] = ext_op0(in_0_i[l*IN_SIZE_0 +: IN_SIZE_0], sign_0_i)
                                 * ext_op1(in_1_i[l*IN_SIZE_1 +: IN_SIZE_1], sign_1_i);
        end
    end

    dot_acc_tree #(
        .LANES (LANES),
        .P_W   (P_W),
        .T_W   (T_W)
    ) u_tree (
        .prod_i (s1_prod_q),
        .sum_o  (tree_sum_s)
    );

    // S1/S2 next state: advance on en, otherwise hold.
    always_comb begin
        if (en_s) begin
            s1_valid_d = valid_i;
            s1_last_d  = last_i;
            s1_prod_d  = prod_s;
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_sum_d   = tree_sum_s;
        end else begin
            s1_valid_d = s1_valid_q;
            s1_last_d  = s1_last_q;
            s1_prod_d  = s1_prod_q;
            s2_valid_d = s2_valid_q;
            s2_last_d  = s2_last_q;
            s2_sum_d   = s2_sum_q;
        end
    end

    assign acc_step_s = en_s && s2_valid_q;
    assign base_s     = first_q ? {ACC_SIZE{1'b0}} : acc_q;
    assign add_s      = ACC_SIZE'($signed(s2_sum_q));
    assign raw_s      = base_s + add_s;

`ifdef DOT_ACC_SATURATE_EN
    localparam logic [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'(sat_max(ACC_SIZE));
    localparam logic [ACC_SIZE-1:0] SAT_MIN = ACC_SIZE'(sat_min(ACC_SIZE));

    logic wrap_ovf_s;
    logic sticky_q, sticky_d;
    logic ovf_q,    ovf_d;

    assign wrap_ovf_s = (base_s[ACC_SIZE-1] == add_s[ACC_SIZE-1])
                     && (raw_s[ACC_SIZE-1] != base_s[ACC_SIZE-1]);
    assign overflow_o = ovf_q;

    // Once saturated, the accumulator stays pinned until the packet closes.
    always_comb begin
        if (sticky_q) begin
            acc_next_s = acc_q;
        end else if (wrap_ovf_s) begin
            acc_next_s = add_s[ACC_SIZE-1] ? SAT_MIN : SAT_MAX;
        end else begin
            acc_next_s = raw_s;
        end
    end

    // Sticky overflow follows the open packet and is latched alongside each result.
    always_comb begin
        if (acc_step_s && s2_last_q) begin
            sticky_d = 1'b0;
            ovf_d    = sticky_q | wrap_ovf_s;
        end else if (acc_step_s) begin
            sticky_d = sticky_q | wrap_ovf_s;
            ovf_d    = ovf_q;
        end else begin
            sticky_d = sticky_q;
            ovf_d    = ovf_q;
        end
    end

    // Overflow state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            ovf_q    <= ovf_d;
        end
    end
`else
    assign overflow_o = 1'b0;

    // Plain modular accumulation.
    always_comb begin
        acc_next_s = raw_s;
    end
`endif

    // Accumulator and output register; a result may land in the same cycle the old one leaves.
    always_comb begin
        if (acc_step_s && s2_last_q) begin
            acc_d       = acc_q;
            first_d     = 1'b1;
            out_valid_d = 1'b1;
            out_d       = acc_next_s;
        end else if (acc_step_s) begin
            acc_d       = acc_next_s;
            first_d     = 1'b0;
            out_valid_d = out_valid_q && !out_ready_i;
            out_d       = out_q;
        end else begin
            acc_d       = acc_q;
            first_d     = first_q;
            out_valid_d = out_valid_q && !out_ready_i;
            out_d       = out_q;
        end
    end

    // Pipeline state registers; reset drops any partial packet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_sum_q    <= s2_sum_d;
            acc_q       <= acc_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

endmodule

// File: tb/tb_dot_acc_engine.sv
// Self-checking bench for dot_acc_engine: directed spec cases plus random packets vs. an arithmetic model.
module tb_dot_acc_engine;

    localparam int L   = 8;
    localparam int W0  = 4;
    localparam int W1  = 8;
    localparam int ACC = 24;

    logic              clk = 1'b0;
    logic              rst_i, valid_i, last_i, sign_0_i, sign_1_i, out_ready_i;
    logic              ready_o, out_valid_o, overflow_o;
    logic [L*W0-1:0]   in_0_i;
    logic [L*W1-1:0]   in_1_i;
    logic [ACC-1:0]    out_o;

    always #5 clk = ~clk;

    dot_acc_engine #(
        .IN_SIZE_0 (W0),
        .IN_SIZE_1 (W1),
        .LANES     (L),
        .ACC_GUARD (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .last_i      (last_i),
        .sign_0_i    (sign_0_i),
        .sign_1_i    (sign_1_i),
        .in_0_i      (in_0_i),
        .in_1_i      (in_1_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_o       (out_o),
        .overflow_o  (overflow_o)
    );

    typedef struct {
        logic [ACC-1:0] val;
        logic           ovf;
    } res_t;

    int             total = 0;
    int             bad = 0;
    res_t           exp_q[$];
    longint         part_acc = 0;
    bit             part_ovf = 1'b0;
    logic [ACC-1:0] last_out = '0;
    logic           last_ovf = 1'b0;
    int             n_out = 0;
    bit             accepted = 1'b0;

`ifdef DOT_ACC_SATURATE_EN
    localparam longint SMAX = (longint'(1) << (ACC - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (ACC - 1));
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint beat_sum(input logic [L*W0-1:0] a, input logic [L*W1-1:0] b,
                                        input logic s0, input logic s1);
        longint sum = 0;
        for (int l = 0; l < L; l++) begin
            longint x = longint'(a[l*W0 +: W0]);
            longint y = longint'(b[l*W1 +: W1]);
            if (s0 && x >= 8) x -= 16;
            if (s1 && y >= 128) y -= 256;
            sum += x * y;
        end
        return sum;
    endfunction

    task automatic accept_beat();
        longint s;
        res_t   r;
        s = beat_sum(in_0_i, in_1_i, sign_0_i, sign_1_i);
`ifdef DOT_ACC_SATURATE_EN
        if (!part_ovf) begin
            part_acc += s;
            if (part_acc > SMAX) begin
                part_acc = SMAX;
                part_ovf = 1'b1;
            end else if (part_acc < SMIN) begin
                part_acc = SMIN;
                part_ovf = 1'b1;
            end
        end
`else
        part_acc += s;
`endif
        if (last_i) begin
            r.val = part_acc[ACC-1:0];
            r.ovf = part_ovf;
            exp_q.push_back(r);
            part_acc = 0;
            part_ovf = 1'b0;
        end
    endtask

    // One clock: observe at negedge (handshakes for the coming edge), then return #1 after posedge.
    task automatic step();
        res_t e;
        @(negedge clk);
        accepted = 1'b0;
        chk("ready", {63'd0, ready_o}, {63'd0, !rst_i && !(out_valid_o && !out_ready_i)});
        if (out_valid_o && out_ready_i) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL extra_result observed=%0h expected=none", out_o);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", {40'd0, out_o}, {40'd0, e.val});
                chk("overflow", {63'd0, overflow_o}, {63'd0, e.ovf});
            end
            last_out = out_o;
            last_ovf = overflow_o;
            n_out++;
        end
        if (rst_i) begin
            exp_q.delete();
            part_acc = 0;
            part_ovf = 1'b0;
        end else if (valid_i && ready_o) begin
            accept_beat();
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L*W0-1:0] rep0(input int v);
        logic [W0-1:0] t = W0'(v);
        return {L{t}};
    endfunction

    function automatic logic [L*W1-1:0] rep1(input int v);
        logic [W1-1:0] t = W1'(v);
        return {L{t}};
    endfunction

    task automatic set_beat(input logic [L*W0-1:0] a, input logic [L*W1-1:0] b,
                            input logic s0, input logic s1, input logic lst);
        valid_i  = 1'b1;
        in_0_i   = a;
        in_1_i   = b;
        sign_0_i = s0;
        sign_1_i = s1;
        last_i   = lst;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic drain(input string tag);
        idle();
        out_ready_i = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        step();
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // Present one single-beat packet and verify the 3-cycle latency and the value.
    task automatic single_beat(input string tag, input int a, input int b,
                               input logic s0, input logic s1, input logic [ACC-1:0] expv);
        set_beat(rep0(a), rep1(b), s0, s1, 1'b1);
        step();
        idle();
        step();
        chk({tag, "_lat_e1"}, {63'd0, out_valid_o}, 64'd0);
        step();
        chk({tag, "_lat_e2"}, {63'd0, out_valid_o}, 64'd1);
        chk({tag, "_value"}, {40'd0, out_o}, {40'd0, expv});
        drain({tag, "_drain"});
    endtask

    initial begin
        int n_before;
        int budget;
        rst_i = 1'b1;
        out_ready_i = 1'b1;
        idle();
        in_0_i = '0;
        in_1_i = '0;
        sign_0_i = 1'b1;
        sign_1_i = 1'b1;
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        step();
        step();
        chk("reset_out_valid", {63'd0, out_valid_o}, 64'd0);
        chk("reset_out", {40'd0, out_o}, 64'd0);
        chk("reset_overflow", {63'd0, overflow_o}, 64'd0);
        rst_i = 1'b0;
        #1;
        chk("ready_after_reset", {63'd0, ready_o}, 64'd1);

        single_beat("signed_max", 7, 127, 1'b1, 1'b1, 24'd7112);
        single_beat("signed_min", -8, -128, 1'b1, 1'b1, 24'd8192);
        single_beat("unsigned", 15, 255, 1'b0, 1'b0, 24'd30600);
        single_beat("mixed", 15, 255, 1'b1, 1'b0, 24'hFFF808);

        // Four-beat packet of 1x1 yields exactly one result of 32.
        n_before = n_out;
        for (int i = 0; i < 4; i++) begin
            set_beat(rep0(1), rep1(1), 1'b1, 1'b1, i == 3);
            step();
        end
        drain("multi_drain");
        chk("multi_count", 64'(n_out - n_before), 64'd1);
        chk("multi_value", {40'd0, last_out}, 64'd32);

        // Backpressure: stream single-beat packets while the consumer stalls.
        out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_beat({$urandom, $urandom} >> 32, {$urandom, $urandom},
                     1'($urandom), 1'($urandom), 1'b1);
            step();
        end
        chk("bp_ready_low", {63'd0, ready_o}, 64'd0);
        chk("bp_held_valid", {63'd0, out_valid_o}, 64'd1);
        drain("bp_drain");

        // Reset in the middle of a four-beat packet.
        for (int i = 0; i < 2; i++) begin
            set_beat(rep0(5), rep1(100), 1'b1, 1'b1, 1'b0);
            step();
        end
        idle();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        set_beat(rep0(3), rep1(2), 1'b1, 1'b1, 1'b1);
        step();
        drain("rst_drain");
        chk("rst_fresh_value", {40'd0, last_out}, 64'd48);

        // Random packets with random gaps, signs and consumer stalls.
        for (int p = 0; p < 40; p++) begin
            int len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                set_beat({$urandom, $urandom} >> 32, {$urandom, $urandom},
                         1'($urandom), 1'($urandom), b == len - 1);
                budget = 0;
                do begin
                    out_ready_i = ($urandom_range(0, 9) < 7);
                    step();
                    budget++;
                end while (!accepted && budget < 50);
                chk("rand_accept", {63'd0, accepted}, 64'd1);
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    step();
                end
            end
        end
        drain("rand_drain");

        // Long packet that exceeds the accumulator range.
        out_ready_i = 1'b1;
        for (int i = 0; i < 1025; i++) begin
            set_beat(rep0(-8), rep1(-128), 1'b1, 1'b1, i == 1024);
            step();
        end
        drain("ovf_drain");
`ifdef DOT_ACC_SATURATE_EN
        chk("ovf_value", {40'd0, last_out}, 64'h7FFFFF);
        chk("ovf_flag", {63'd0, last_ovf}, 64'd1);
`else
        chk("ovf_value", {40'd0, last_out}, 64'h802000);
        chk("ovf_flag", {63'd0, last_ovf}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
